// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator for the decode stage.
// Valid/ready boundary with a 2-entry skid buffer and flush.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_type,
  output logic                 out_unknown,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam bit RV64 = (XLEN == 64);

  typedef enum logic [2:0] {
    T_NONE  = 3'd0,
    T_I     = 3'd1,
    T_S     = 3'd2,
    T_B     = 3'd3,
    T_U     = 3'd4,
    T_J     = 3'd5,
    T_SHAMT = 3'd6,
    T_ZIMM  = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]      imm;
    imm_type_e            typ;
    logic                 unk;
    logic [TAG_WIDTH-1:0] tag;
  } beat_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_sh;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] sh5, sh_op, zimm;

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8],
                                1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21],
                                1'b0}));
  assign sh5   = XLEN'(in_inst[24:20]);
  // RV64 OP-IMM shifts carry a 6-bit shamt; *W shifts stay 5-bit.
  assign sh_op = RV64 ? XLEN'(in_inst[25:20]) : sh5;
  assign zimm  = XLEN'(in_inst[19:15]);

  beat_t in_b;

  always_comb begin
    in_b     = '0;
    in_b.tag = in_tag;
    unique case (1'b1)
      opc == 7'b0010011: begin
        in_b.typ = is_sh ? T_SHAMT : T_I;
        in_b.imm = is_sh ? sh_op : imm_i;
      end
      opc == 7'b0011011: begin
        if (RV64) begin
          in_b.typ = is_sh ? T_SHAMT : T_I;
          in_b.imm = is_sh ? sh5 : imm_i;
        end else begin
          in_b.unk = 1'b1;
        end
      end
      opc == 7'b0000011,
      opc == 7'b1100111,
      opc == 7'b0001111: begin
        in_b.typ = T_I;
        in_b.imm = imm_i;
      end
      opc == 7'b0100011: begin
        in_b.typ = T_S;
        in_b.imm = imm_s;
      end
      opc == 7'b1100011: begin
        in_b.typ = T_B;
        in_b.imm = imm_b;
      end
      opc == 7'b0110111,
      opc == 7'b0010111: begin
        in_b.typ = T_U;
        in_b.imm = imm_u;
      end
      opc == 7'b1101111: begin
        in_b.typ = T_J;
        in_b.imm = imm_j;
      end
      opc == 7'b0110011,
      opc == 7'b0111011: begin
        in_b.typ = T_NONE;
      end
      opc == 7'b1110011: begin
        unique case (1'b1)
          f3[2] && (f3[1:0] != 2'b00): begin
            in_b.typ = T_ZIMM;
            in_b.imm = zimm;
          end
          !f3[2] && (f3[1:0] != 2'b00): begin
            in_b.typ = T_I;
            in_b.imm = imm_i;
          end
          default: in_b.typ = T_NONE;
        endcase
      end
      default: in_b.unk = 1'b1;
    endcase
  end

  beat_t m_q, m_d, s_q, s_d;
  logic  m_v_q, m_v_d, s_v_q, s_v_d;
  logic  accept, fire, load_m;

  assign in_ready  = ~s_v_q;
  assign out_valid = m_v_q;
  assign accept    = in_valid & in_ready;
  assign fire      = m_v_q & out_ready;
  assign load_m    = ~m_v_q | fire;

  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (load_m) begin
      if (s_v_q) begin
        m_d   = s_q;
        m_v_d = 1'b1;
        s_v_d = accept;
        if (accept) s_d = in_b;
      end else if (accept) begin
        m_d   = in_b;
        m_v_d = 1'b1;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (accept) begin
      s_d   = in_b;
      s_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      s_q   <= '0;
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
    end
  end

  assign out_imm     = m_q.imm;
  assign out_type    = m_q.typ;
  assign out_unknown = m_q.unk;
  assign out_tag     = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 and RV64 instances
// share one input stream; each output set is checked.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_unk;
  logic [31:0] a_imm, a_tag;
  logic [2:0]  a_type;

  logic        b_in_ready, b_out_valid, b_unk;
  logic [63:0] b_imm;
  logic [31:0] b_tag;
  logic [2:0]  b_type;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_imm), .out_type(a_type),
    .out_unknown(a_unk), .out_tag(a_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_WIDTH(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_imm), .out_type(b_type),
    .out_unknown(b_unk), .out_tag(b_tag)
  );

  task automatic chk(input string nm,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst,
                       input logic [31:0] tag);
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
  endtask

  // One-beat decode check on the RV32 instance.
  task automatic dec32(input string nm,
                       input logic [31:0] inst,
                       input logic [31:0] tag,
                       input logic [31:0] imm,
                       input logic [2:0]  typ,
                       input logic        unk);
    drive(inst, tag);
    tick();
    chk({nm, "_v"},   64'(a_out_valid), 64'd1);
    chk({nm, "_imm"}, 64'(a_imm), 64'(imm));
    chk({nm, "_typ"}, 64'(a_type), 64'(typ));
    chk({nm, "_unk"}, 64'(a_unk), 64'(unk));
    chk({nm, "_tag"}, 64'(a_tag), 64'(tag));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_ov",  64'(a_out_valid), 64'd0);
    chk("rst_ir",  64'(a_in_ready),  64'd1);
    chk("rst_imm", 64'(a_imm),       64'd0);
    chk("rst_typ", 64'(a_type),      64'd0);
    chk("rst_unk", 64'(a_unk),       64'd0);
    chk("rst_tag", 64'(a_tag),       64'd0);
    chk("rst_imm64", b_imm,          64'd0);
    chk("rst_ov64", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    dec32("addi", 32'hFFF00093, 32'h11, 32'hFFFFFFFF, 3'd1, 1'b0);
    chk("addi_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
    dec32("srai", 32'h4030D093, 32'h12, 32'h00000003, 3'd6, 1'b0);
    chk("srai_imm64", b_imm, 64'd3);
    dec32("beq",  32'hFE000EE3, 32'h13, 32'hFFFFFFFC, 3'd3, 1'b0);
    dec32("sw",   32'hFE20AC23, 32'h14, 32'hFFFFFFF8, 3'd2, 1'b0);
    dec32("jal",  32'h001000EF, 32'h15, 32'h00000800, 3'd5, 1'b0);
    dec32("csri", 32'h3002D073, 32'h16, 32'h00000005, 3'd7, 1'b0);
    dec32("unk",  32'h0000007F, 32'h17, 32'h00000000, 3'd0, 1'b1);
    chk("unk_unk64", 64'(b_unk), 64'd1);
    dec32("add",  32'h002081B3, 32'h18, 32'h00000000, 3'd0, 1'b0);
    dec32("ecall", 32'h00000073, 32'h19, 32'h00000000, 3'd0, 1'b0);
    dec32("lui",  32'h80000537, 32'h1A, 32'h80000000, 3'd4, 1'b0);
    chk("lui_imm64", b_imm, 64'hFFFFFFFF80000000);
    chk("lui_typ64", 64'(b_type), 64'd4);
    dec32("slli", 32'h03F09093, 32'h1B, 32'h0000001F, 3'd6, 1'b0);
    chk("slli_imm64", b_imm, 64'd63);
    chk("slli_typ64", 64'(b_type), 64'd6);
    dec32("addiw", 32'h0010809B, 32'h1C, 32'h00000000, 3'd0, 1'b1);
    chk("addiw_imm64", b_imm, 64'd1);
    chk("addiw_typ64", 64'(b_type), 64'd1);
    chk("addiw_unk64", 64'(b_unk), 64'd0);

    in_valid = 1'b0;
    tick();
    chk("drain_ov", 64'(a_out_valid), 64'd0);

    // Backpressure: A in main, B in skid, C held off.
    out_ready = 1'b0;
    drive(32'hFFF00093, 32'hA0);
    tick();
    chk("bp_a_tag", 64'(a_tag), 64'hA0);
    chk("bp_a_ir",  64'(a_in_ready), 64'd1);
    drive(32'h4030D093, 32'hB0);
    tick();
    chk("bp_b_tag", 64'(a_tag), 64'hA0);
    chk("bp_b_ir",  64'(a_in_ready), 64'd0);
    chk("bp_b_imm", 64'(a_imm), 64'hFFFFFFFF);
    drive(32'hFE000EE3, 32'hC0);
    tick();
    chk("bp_c_tag", 64'(a_tag), 64'hA0);
    chk("bp_c_ir",  64'(a_in_ready), 64'd0);
    chk("bp_c_ov",  64'(a_out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("em_b_tag", 64'(a_tag), 64'hB0);
    chk("em_b_imm", 64'(a_imm), 64'd3);
    chk("em_b_ir",  64'(a_in_ready), 64'd1);
    tick();
    chk("em_c_tag", 64'(a_tag), 64'hC0);
    chk("em_c_imm", 64'(a_imm), 64'hFFFFFFFC);
    in_valid = 1'b0;
    tick();
    chk("em_end_ov", 64'(a_out_valid), 64'd0);

    // Flush with both entries full and a beat offered.
    out_ready = 1'b0;
    drive(32'hFFF00093, 32'hD0);
    tick();
    drive(32'hFFF00093, 32'hD1);
    tick();
    chk("fl_full_ir", 64'(a_in_ready), 64'd0);
    flush = 1'b1;
    drive(32'hFFF00093, 32'hD2);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", 64'(a_out_valid), 64'd0);
    chk("fl_ir", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_ov2", 64'(a_out_valid), 64'd0);
    drive(32'h3002D073, 32'hE0);
    tick();
    in_valid = 1'b0;
    chk("fl_next_tag", 64'(a_tag), 64'hE0);
    chk("fl_next_imm", 64'(a_imm), 64'd5);

    // Asynchronous reset mid-cycle, away from any edge.
    out_ready = 1'b0;
    drive(32'hFFF00093, 32'hF0);
    tick();
    drive(32'hFFF00093, 32'hF1);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 64'(a_out_valid), 64'd0);
    chk("ar_ir", 64'(a_in_ready), 64'd1);
    chk("ar_tag", 64'(a_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_after_ov", 64'(a_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
